// File: rtl/rtc_reset_sequencer_if.sv
// Signal bundle for the RTC staged reset sequencer.
// Groups the soft-reset handshake, per-stage reset outputs, ready and debug state.
// Master modport belongs to the soft-reset requester; slave modport belongs to the sequencer.
interface rtc_reset_sequencer_if;
  logic       soft_req;
  logic       soft_ack;
  logic [2:0] reset_out;
  logic [2:0] reset_n_out;
  logic       ready;
  logic [2:0] state;

  modport master (
    output soft_req,
    input  soft_ack,
    input  reset_out,
    input  reset_n_out,
    input  ready,
    input  state
  );

  modport slave (
    input  soft_req,
    output soft_ack,
    output reset_out,
    output reset_n_out,
    output ready,
    output state
  );
endinterface

// File: rtl/rtc_reset_sequencer.sv
// Staged reset controller for the RTC peripheral subsystem (clk_peripheral domain).
// Releases stage 0 (AXI interconnect), stage 1 (I2C master), stage 2 (RTC core) in order,
// and raises ready once all three are out of reset. All outputs are registered.
// Optional feature: define RTC_RESET_SYNC_EN to pass soft_req through a 2-flop synchronizer
// (soft_req may then be asynchronous; every soft_req timing shifts 2 edges later).
//
// Soft-reset handshake (4-phase, level based): the requester raises soft_req and keeps it high;
// the sequencer answers with soft_ack=1 while it holds every domain in reset (DRAIN). The
// requester drops soft_req, the sequencer drops soft_ack on the edge it samples soft_req low and
// restarts the release sequence from HOLD. A new request may only start after soft_ack is low.
module rtc_reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 8
) (
  input  logic                  clk_peripheral,
  input  logic                  reset,
  rtc_reset_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    REL0  = 3'd1,
    REL1  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Kept as a plain vector so illegal codes 5-7 are representable and recoverable.
  logic [2:0]       state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       reset_out_q, reset_out_d;
  logic             ready_q, ready_d;
  logic             soft_ack_q, soft_ack_d;
  logic             soft_s;

`ifdef RTC_RESET_SYNC_EN
  logic soft_meta_q, soft_sync_q;

  // Two-flop synchronizer for an asynchronous soft_req.
  always_ff @(posedge clk_peripheral or posedge reset) begin
    if (reset) begin
      soft_meta_q <= 1'b0;
      soft_sync_q <= 1'b0;
    end else begin
      soft_meta_q <= bus.soft_req;
      soft_sync_q <= soft_meta_q;
    end
  end

  assign soft_s = soft_sync_q;
`else
  assign soft_s = bus.soft_req;
`endif

  // State, counter and registered outputs; reset forces every domain into reset at once.
  always_ff @(posedge clk_peripheral or posedge reset) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      reset_out_q <= 3'b111;
      ready_q     <= 1'b0;
      soft_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reset_out_q <= reset_out_d;
      ready_q     <= ready_d;
      soft_ack_q  <= soft_ack_d;
    end
  end

  // Next state and counter; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d     = HOLD;
    cnt_d       = '0;
    reset_out_d = 3'b111;
    ready_d     = 1'b0;
    soft_ack_d  = 1'b0;

    case (state_q)
      HOLD: begin
        if (soft_s)                  state_d = DRAIN;
        else if (cnt_q == HOLD_LAST) state_d = REL0;
        else begin
          state_d = HOLD;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      REL0: begin
        if (soft_s)                 state_d = DRAIN;
        else if (cnt_q == GAP_LAST) state_d = REL1;
        else begin
          state_d = REL0;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      REL1: begin
        if (soft_s)                 state_d = DRAIN;
        else if (cnt_q == GAP_LAST) state_d = RUN;
        else begin
          state_d = REL1;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (soft_s) state_d = DRAIN;
        else begin
          state_d = RUN;
          cnt_d   = cnt_q;
        end
      end
      DRAIN: begin
        if (soft_s) begin
          state_d = DRAIN;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = HOLD;
    endcase

    case (state_d)
      REL0:    reset_out_d = 3'b110;
      REL1:    reset_out_d = 3'b100;
      RUN: begin
        reset_out_d = 3'b000;
        ready_d     = 1'b1;
      end
      DRAIN:   soft_ack_d  = 1'b1;
      default: reset_out_d = 3'b111;
    endcase
  end

  assign bus.reset_out   = reset_out_q;
  assign bus.reset_n_out = ~reset_out_q;
  assign bus.ready       = ready_q;
  assign bus.soft_ack    = soft_ack_q;
  assign bus.state       = state_q;

endmodule
